inst_sequencer: RTL and testbench

Parametrised successor to the single-instruction matrix controller. It buffers incoming instructions in a small FIFO and decodes each one. For each instruction it fetches the A/B/C/D operand descriptors from the descriptor table over a pipelined read port, then runs a built-in two-level loop engine. The loop engine issues operand addresses to NUM_BANKS memory banks with datapath backpressure and delayed D-bank write enables. It sits between the host instruction interface and the bank memories / MAC datapath.

---
 rtl/inst_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_inst_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sequencer.sv
// Instruction sequencer: FIFO-buffered decode, descriptor fetch and two-level address loop engine.
// Optional macro PERF_CNT_EN adds saturating busy/stall cycle counters.
module inst_sequencer #(
  parameter int unsigned INST_WIDTH = 27,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LOOP_W     = 11,
  parameter int unsigned PIPE_LAT   = 3,
  localparam int unsigned BANK_W    = $clog2(NUM_BANKS),
  localparam int unsigned AW        = BANK_W + ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INST_WIDTH-1:0] inst,
  input  logic                  inst_valid,
  output logic                  inst_ready,
  output logic                  desc_rd_en,
  output logic [3:0]            desc_addr,
  input  logic [63:0]           desc_rd_data,
  output logic [AW-1:0]         rd_addr_a,
  output logic [AW-1:0]         rd_addr_b,
  output logic [AW-1:0]         rd_addr_c,
  output logic                  dp_valid,
  input  logic                  dp_ready,
  output logic [2:0]            dp_mode,
  output logic [AW-1:0]         wr_addr_d,
  output logic [NUM_BANKS-1:0]  wr_en_bank,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]           cyc_busy,
  output logic [31:0]           cyc_stall
`endif
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned DRAIN_W = $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {StIdle, StDec, StChk, StEx, StDrain} state_e;

  state_e                state;
  logic [INST_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        fifo_cnt;
  logic                  fifo_empty, fifo_full, push, pop;
  logic [INST_WIDTH-1:0] head, inst_q;
  logic [2:0]            k_q;
  logic [AW-1:0]         base_a, base_b, base_c, base_d;
  logic [LOOP_W-1:0]     outer_max, outer_q;
  logic [7:0]            inner_q;
  logic [ADDR_WIDTH-1:0] offset_q;
  logic [DRAIN_W-1:0]    drain_q;
  logic                  nop_done_q;
  logic [2:0]            opcode;
  logic [3:0]            idx_a, idx_b, idx_c, idx_d;
  logic [7:0]            ilen;
  logic [BANK_W-1:0]     bank_a, bank_b, bank_d;
  logic                  conflict, beat, beat_wr;
  logic [AW-1:0]         addr_d_cur;
  logic [PIPE_LAT-1:0]   pipe_en;
  logic [AW-1:0]         pipe_addr [PIPE_LAT];
  logic                  desc_unused;

  // Field decode of the latched instruction.
  assign opcode = inst_q[INST_WIDTH-1 -: 3];
  assign idx_a  = inst_q[INST_WIDTH-4 -: 4];
  assign idx_b  = inst_q[INST_WIDTH-8 -: 4];
  assign idx_c  = inst_q[INST_WIDTH-12 -: 4];
  assign idx_d  = inst_q[INST_WIDTH-16 -: 4];
  assign ilen   = inst_q[INST_WIDTH-20 -: 8];

  assign bank_a = base_a[AW-1:ADDR_WIDTH];
  assign bank_b = base_b[AW-1:ADDR_WIDTH];
  assign bank_d = base_d[AW-1:ADDR_WIDTH];

  assign desc_unused = ^desc_rd_data;

  // Instruction FIFO.
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (PTR_W + 1)'(FIFO_DEPTH));
  assign inst_ready = ~fifo_full;
  assign push       = inst_valid & ~fifo_full;
  assign pop        = (state == StIdle) & ~fifo_empty;
  assign head       = fifo_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= inst;
  end

  assign conflict = opcode[2] & ((bank_d == bank_a) | (bank_d == bank_b));
  assign beat     = (state == StEx) & dp_ready;
  assign beat_wr  = beat & opcode[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      inst_q     <= '0;
      k_q        <= '0;
      base_a     <= '0;
      base_b     <= '0;
      base_c     <= '0;
      base_d     <= '0;
      outer_max  <= '0;
      outer_q    <= '0;
      inner_q    <= '0;
      offset_q   <= '0;
      drain_q    <= '0;
      nop_done_q <= 1'b0;
    end else begin
      nop_done_q <= 1'b0;
      unique case (state)
        StIdle: begin
          if (pop) begin
            if (head[INST_WIDTH-1 -: 3] == 3'b000) begin
              nop_done_q <= 1'b1;
            end else begin
              inst_q <= head;
              k_q    <= '0;
              state  <= StDec;
            end
          end
        end
        StDec: begin
          k_q <= k_q + 3'd1;
          // Read data trails the strobe by one cycle, hence k=1..4.
          case (k_q)
            3'd1: begin
              base_a    <= desc_rd_data[AW-1:0];
              outer_max <= desc_rd_data[32+LOOP_W-1:32];
            end
            3'd2:    base_b <= desc_rd_data[AW-1:0];
            3'd3:    base_c <= desc_rd_data[AW-1:0];
            3'd4:    base_d <= desc_rd_data[AW-1:0];
            default: ;
          endcase
          if (k_q == 3'd4) state <= StChk;
        end
        StChk: begin
          inner_q  <= '0;
          outer_q  <= '0;
          offset_q <= '0;
          state    <= conflict ? StIdle : StEx;
        end
        StEx: begin
          if (dp_ready) begin
            offset_q <= offset_q + ADDR_WIDTH'(1);
            if (inner_q == ilen) begin
              inner_q <= '0;
              if (outer_q == outer_max) begin
                drain_q <= '0;
                state   <= StDrain;
              end else begin
                outer_q <= outer_q + LOOP_W'(1);
              end
            end else begin
              inner_q <= inner_q + 8'd1;
            end
          end
        end
        StDrain: begin
          drain_q <= drain_q + DRAIN_W'(1);
          if (drain_q == DRAIN_W'(PIPE_LAT - 1)) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Write pipeline tracks datapath latency; never stalls.
  assign addr_d_cur = {bank_d, base_d[ADDR_WIDTH-1:0] + offset_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_en <= '0;
      for (int i = 0; i < PIPE_LAT; i++) pipe_addr[i] <= '0;
    end else begin
      pipe_en[0]   <= beat_wr;
      pipe_addr[0] <= addr_d_cur;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_en[i]   <= pipe_en[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  assign wr_addr_d  = pipe_addr[PIPE_LAT-1];
  assign wr_en_bank = pipe_en[PIPE_LAT-1] ?
                      (NUM_BANKS'(1) << pipe_addr[PIPE_LAT-1][AW-1:ADDR_WIDTH]) : '0;

  assign rd_addr_a = {bank_a, base_a[ADDR_WIDTH-1:0] + offset_q};
  assign rd_addr_b = {bank_b, base_b[ADDR_WIDTH-1:0] + offset_q};
  assign rd_addr_c = {base_c[AW-1:ADDR_WIDTH], base_c[ADDR_WIDTH-1:0] + offset_q};

  always_comb begin
    desc_addr = 4'd0;
    if (desc_rd_en) begin
      unique case (k_q[1:0])
        2'd0: desc_addr = idx_a;
        2'd1: desc_addr = idx_b;
        2'd2: desc_addr = idx_c;
        2'd3: desc_addr = idx_d;
      endcase
    end
  end

  assign desc_rd_en = (state == StDec) & (k_q < 3'd4);
  assign dp_valid   = (state == StEx);
  assign dp_mode    = (state == StIdle) ? 3'b000 : opcode;
  assign busy       = (state != StIdle) | ~fifo_empty;
  assign err        = (state == StChk) & conflict;
  assign done       = nop_done_q |
                      ((state == StDrain) & (drain_q == DRAIN_W'(PIPE_LAT - 1)));

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_busy  <= '0;
      cyc_stall <= '0;
    end else begin
      if (busy && (cyc_busy != '1)) cyc_busy <= cyc_busy + 32'd1;
      if ((state == StEx) && !dp_ready && (cyc_stall != '1)) cyc_stall <= cyc_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed self-checking bench for inst_sequencer with a behavioural descriptor table.
module tb_inst_sequencer;

  logic        clk;
  logic        rst;
  logic [26:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        desc_rd_en;
  logic [3:0]  desc_addr;
  logic [63:0] desc_rd_data;
  logic [13:0] rd_addr_a, rd_addr_b, rd_addr_c;
  logic        dp_valid;
  logic        dp_ready;
  logic [2:0]  dp_mode;
  logic [13:0] wr_addr_d;
  logic [3:0]  wr_en_bank;
  logic        busy, done, err;
`ifdef PERF_CNT_EN
  logic [31:0] cyc_busy, cyc_stall;
`endif

  inst_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .desc_rd_en   (desc_rd_en),
    .desc_addr    (desc_addr),
    .desc_rd_data (desc_rd_data),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_addr_c    (rd_addr_c),
    .dp_valid     (dp_valid),
    .dp_ready     (dp_ready),
    .dp_mode      (dp_mode),
    .wr_addr_d    (wr_addr_d),
    .wr_en_bank   (wr_en_bank),
    .busy         (busy),
    .done         (done),
    .err          (err)
`ifdef PERF_CNT_EN
    ,
    .cyc_busy     (cyc_busy),
    .cyc_stall    (cyc_stall)
`endif
  );

  logic [63:0] desc_mem [16];
  int          vec_cnt = 0;
  int          fail_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Descriptor table with one-cycle read latency.
  initial desc_rd_data = '0;
  always @(posedge clk) begin
    if (desc_rd_en) desc_rd_data <= desc_mem[desc_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [26:0] w);
    inst       = w;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
  endtask

  function automatic logic [26:0] mk(input logic [2:0] op, input logic [3:0] a,
                                     input logic [3:0] b, input logic [3:0] c,
                                     input logic [3:0] d, input logic [7:0] il);
    return {op, a, b, c, d, il};
  endfunction

  logic [26:0] add_inst, err_inst, x0, wrap_inst, outer_inst;
  logic [26:0] yw [5];
  logic [13:0] cseen [6];
  logic [13:0] wexp [4];
  int          stall_off [7];
  int          acc_c [5];
  int          nacc, ndone, nbeg, widx;
  logic        prev_v, acc;
  logic [31:0] stall0;

  initial begin
    rst = 1'b1; inst = '0; inst_valid = 1'b0; dp_ready = 1'b0;
    stall0 = '0;
    for (int i = 0; i < 16; i++) desc_mem[i] = 64'h0;
    desc_mem[0]  = 64'h0000_0002_0000_1200;  // outer count-1 = 2, {1,0x200}
    desc_mem[1]  = 64'h0000_0000_0000_0010;  // {0,0x010}
    desc_mem[2]  = 64'h0000_0000_0000_1020;  // {1,0x020}
    desc_mem[3]  = 64'h0000_0000_0000_3030;  // {3,0x030}
    desc_mem[4]  = 64'h0000_0000_0000_2100;  // {2,0x100}
    desc_mem[5]  = 64'h0000_0000_0000_0050;  // {0,0x050}
    desc_mem[6]  = 64'h0000_0000_0000_1060;
    desc_mem[7]  = 64'h0000_0000_0000_3070;
    desc_mem[8]  = 64'h0000_0000_0000_0080;  // D in bank 0 -> conflict with A
    for (int j = 9; j < 15; j++) desc_mem[j] = 64'h3000 + 64'(j * 16);
    desc_mem[15] = 64'h0000_0000_0000_3FFE;  // {3,0xFFE}

    add_inst   = mk(3'b101, 4'd1, 4'd2, 4'd3, 4'd4, 8'd3);
    err_inst   = mk(3'b110, 4'd5, 4'd6, 4'd7, 4'd8, 8'd1);
    x0         = mk(3'b001, 4'd1, 4'd2, 4'd9, 4'd4, 8'd1);
    wrap_inst  = mk(3'b001, 4'd15, 4'd2, 4'd3, 4'd4, 8'd3);
    outer_inst = mk(3'b011, 4'd0, 4'd2, 4'd3, 4'd4, 8'd1);
    for (int k = 0; k < 5; k++) yw[k] = mk(3'b001, 4'd1, 4'd2, 4'(10 + k), 4'd4, 8'd1);
    stall_off = '{0, 1, 1, 1, 1, 2, 3};
    wexp = '{14'h3FFE, 14'h3FFF, 14'h3000, 14'h3001};

    // Reset state
    #3;
    chk("rst_inst_ready", 32'(inst_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dp_valid", 32'(dp_valid), 0);
    chk("rst_wr_en", 32'(wr_en_bank), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_desc_rd_en", 32'(desc_rd_en), 0);
    chk("rst_dp_mode", 32'(dp_mode), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_inst_ready", 32'(inst_ready), 1);
    chk("idle_busy", 32'(busy), 0);

    // NOP: done the cycle after the pop, never leaves IDLE
    push(mk(3'b000, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0));
    for (int c = 0; c < 4; c++) begin
      chk("nop_done", 32'(done), 32'(c == 1));
      chk("nop_dp_mode", 32'(dp_mode), 0);
      chk("nop_dp_valid", 32'(dp_valid), 0);
      tick();
    end

    // ADD, full-rate datapath
    dp_ready = 1'b1;
    push(add_inst);
    for (int c = 0; c <= 14; c++) begin
      chk("add_valid", 32'(dp_valid), 32'(c >= 7 && c <= 10));
      if (c >= 7 && c <= 10) chk("add_rd_a", 32'(rd_addr_a), 32'h0010 + 32'(c - 7));
      if (c == 7) begin
        chk("add_rd_b", 32'(rd_addr_b), 32'h1020);
        chk("add_rd_c", 32'(rd_addr_c), 32'h3030);
      end
      chk("add_wen", 32'(wr_en_bank), (c >= 10 && c <= 13) ? 32'b0100 : 32'b0);
      if (c >= 10 && c <= 13) chk("add_wr_d", 32'(wr_addr_d), 32'h2100 + 32'(c - 10));
      chk("add_done", 32'(done), 32'(c == 13));
      chk("add_busy", 32'(busy), 32'(c <= 13));
      if (c >= 1 && c <= 4) begin
        chk("add_desc_en", 32'(desc_rd_en), 1);
        chk("add_desc_addr", 32'(desc_addr), 32'(c));
      end
      if (c == 5) chk("add_desc_en_off", 32'(desc_rd_en), 0);
      if (c == 1 || c == 13) chk("add_dp_mode", 32'(dp_mode), 5);
      chk("add_err", 32'(err), 0);
      tick();
    end

    // ADD with backpressure on the second beat for 3 cycles
`ifdef PERF_CNT_EN
    stall0 = cyc_stall;
`endif
    push(add_inst);
    for (int c = 0; c <= 17; c++) begin
      dp_ready = !(c >= 8 && c <= 10);
      chk("stall_valid", 32'(dp_valid), 32'(c >= 7 && c <= 13));
      if (c >= 7 && c <= 13)
        chk("stall_rd_a", 32'(rd_addr_a), 32'h0010 + 32'(stall_off[c-7]));
      widx = (c == 10) ? 0 : (c >= 14 && c <= 16) ? c - 13 : -1;
      chk("stall_wen", 32'(wr_en_bank), (widx >= 0) ? 32'b0100 : 32'b0);
      if (widx >= 0) chk("stall_wr_d", 32'(wr_addr_d), 32'h2100 + 32'(widx));
      chk("stall_done", 32'(done), 32'(c == 16));
      tick();
    end
    dp_ready = 1'b1;
`ifdef PERF_CNT_EN
    chk("stall_cnt", cyc_stall - stall0, 3);
`endif

    // Bank conflict: D bank == A bank with a write opcode
    push(err_inst);
    for (int c = 0; c <= 10; c++) begin
      chk("conf_err", 32'(err), 32'(c == 6));
      chk("conf_valid", 32'(dp_valid), 0);
      chk("conf_wen", 32'(wr_en_bank), 0);
      chk("conf_done", 32'(done), 0);
      if (c >= 7) chk("conf_busy", 32'(busy), 0);
      tick();
    end

    // FIFO fill: 5 offered while the first executes
    push(x0);
    nacc = 0; ndone = 0; nbeg = 0; prev_v = 1'b0;
    for (int k = 0; k < 5; k++) acc_c[k] = -1;
    for (int c = 0; c < 100; c++) begin
      if (c >= 1 && nacc < 5) begin
        inst = yw[nacc];
        inst_valid = 1'b1;
      end else begin
        inst_valid = 1'b0;
      end
      if (c == 5 || c == 11) chk("fifo_full_ready", 32'(inst_ready), 0);
      if (done) ndone++;
      if (dp_valid && !prev_v) begin
        if (nbeg < 6) cseen[nbeg] = rd_addr_c;
        nbeg++;
      end
      prev_v = dp_valid;
      acc = inst_valid && inst_ready;
      tick();
      if (acc) begin
        if (nacc < 5) acc_c[nacc] = c;
        nacc++;
      end
    end
    inst_valid = 1'b0;
    chk("fifo_nacc", nacc, 5);
    chk("fifo_acc0", acc_c[0], 1);
    chk("fifo_acc3", acc_c[3], 4);
    chk("fifo_acc4", acc_c[4], 13);
    chk("fifo_ndone", ndone, 6);
    chk("fifo_nbeg", nbeg, 6);
    for (int k = 0; k < 6; k++)
      if (k < nbeg) chk("fifo_order", 32'(cseen[k]), 32'h3000 + 32'((9 + k) * 16));
    chk("fifo_busy_end", 32'(busy), 0);

    // Address wrap within the bank
    push(wrap_inst);
    for (int c = 0; c <= 15; c++) begin
      chk("wrap_valid", 32'(dp_valid), 32'(c >= 7 && c <= 10));
      if (c >= 7 && c <= 10) chk("wrap_rd_a", 32'(rd_addr_a), 32'(wexp[c-7]));
      chk("wrap_wen", 32'(wr_en_bank), 0);
      tick();
    end

    // Outer loop: 3 passes of 2 beats, contiguous offsets
    push(outer_inst);
    for (int c = 0; c <= 16; c++) begin
      chk("outer_valid", 32'(dp_valid), 32'(c >= 7 && c <= 12));
      if (c >= 7 && c <= 12) chk("outer_rd_a", 32'(rd_addr_a), 32'h1200 + 32'(c - 7));
      chk("outer_done", 32'(done), 32'(c == 15));
      tick();
    end

    // Reset mid-EX aborts without done or writes
    push(add_inst);
    for (int c = 0; c < 8; c++) tick();
    chk("abort_pre_valid", 32'(dp_valid), 1);
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(dp_valid), 0);
    chk("abort_wen", 32'(wr_en_bank), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(inst_ready), 1);
    chk("abort_done", 32'(done), 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("abort_post_wen", 32'(wr_en_bank), 0);
      chk("abort_post_done", 32'(done), 0);
      chk("abort_post_valid", 32'(dp_valid), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule
